// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button bus responder.
package btn_pkg;

  localparam logic [1:0] BTN_OFF_LEVEL = 2'd0;
  localparam logic [1:0] BTN_OFF_PRESS = 2'd1;
  localparam logic [1:0] BTN_OFF_REL   = 2'd2;
  localparam logic [1:0] BTN_OFF_COUNT = 2'd3;

  // Callers zero-extend narrower vectors to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_if.sv
// Bridge-to-button-block bus: word-addressed, single-cycle write strobe, combinational read data.
interface btn_if;

  logic [31:0] btn_addr;
  logic        btn_we;
  logic [31:0] btn_wdata;
  logic [31:0] rdata_btn2bridge;

  modport master (
    output btn_addr,
    output btn_we,
    output btn_wdata,
    input  rdata_btn2bridge
  );

  modport slave (
    input  btn_addr,
    input  btn_we,
    input  btn_wdata,
    output rdata_btn2bridge
  );

endinterface

// File: rtl/btn_debounce.sv
// One-bit 2-flop synchroniser followed by a stable-count debouncer.
// level_next exposes the value level takes at the next edge, for same-cycle edge detection.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic level_next
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            s2;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  assign s2 = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pad};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2 == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = s2;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign level      = level_q;
  assign level_next = level_d;

endmodule

// File: rtl/btn_io.sv
// Push-button bus responder: debounced levels, sticky W1C press/release events and a press counter.
module btn_io
  import btn_pkg::*;
#(
  parameter int unsigned NBTN       = 5,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            btn_clk,
  input  logic            btn_rst,
  input  logic [NBTN-1:0] button,
  btn_if.slave            bus
);

  logic [NBTN-1:0]  level, level_next;
  logic [NBTN-1:0]  rise, fall;
  logic [NBTN-1:0]  press_q, press_d;
  logic [NBTN-1:0]  rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       off;
  logic             wr_press, wr_rel, wr_cnt;
  logic [NBTN-1:0]  clr_mask;
  logic             unused_bus;

  for (genvar i = 0; i < NBTN; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk       (btn_clk),
      .rst       (btn_rst),
      .pad       (button[i]),
      .level     (level[i]),
      .level_next(level_next[i])
    );
  end

  assign rise = level_next & ~level;
  assign fall = ~level_next & level;

  assign off      = bus.btn_addr[3:2];
  assign clr_mask = bus.btn_wdata[NBTN-1:0];
  assign wr_press = bus.btn_we && (off == BTN_OFF_PRESS);
  assign wr_rel   = bus.btn_we && (off == BTN_OFF_REL);
  assign wr_cnt   = bus.btn_we && (off == BTN_OFF_COUNT);
  assign cnt_inc  = CNT_W'(popcount(32'(rise)));

  // Base address is decoded by the bridge; only the word offset matters here.
  assign unused_bus = ^{bus.btn_addr, bus.btn_wdata};

  // A new edge always wins over a same-cycle clear; a COUNT write restarts from this cycle's rises.
  always_comb begin
    press_d = press_q | rise;
    rel_d   = rel_q | fall;
    cnt_d   = cnt_q + cnt_inc;
    if (wr_press) press_d = (press_q & ~clr_mask) | rise;
    if (wr_rel)   rel_d   = (rel_q & ~clr_mask) | fall;
    if (wr_cnt)   cnt_d   = cnt_inc;
  end

  always_ff @(posedge btn_clk or posedge btn_rst) begin
    if (btn_rst) begin
      press_q <= '0;
      rel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.rdata_btn2bridge = '0;
    unique case (off)
      BTN_OFF_LEVEL: bus.rdata_btn2bridge = 32'(level);
      BTN_OFF_PRESS: bus.rdata_btn2bridge = 32'(press_q);
      BTN_OFF_REL:   bus.rdata_btn2bridge = 32'(rel_q);
      BTN_OFF_COUNT: bus.rdata_btn2bridge = 32'(cnt_q);
      default:       bus.rdata_btn2bridge = '0;
    endcase
  end

endmodule

// File: tb/tb_btn_io.sv
// Directed bench for btn_io with DEB_CYCLES=4; a second instance with an 8-bit counter covers wrap.
module tb_btn_io;
  import btn_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] button;
  int         checks;
  int         failures;

  btn_if bus ();
  btn_if bus_w ();

  btn_io #(
    .NBTN      (5),
    .DEB_CYCLES(4),
    .CNT_W     (16)
  ) u_dut (
    .btn_clk(clk),
    .btn_rst(rst),
    .button (button),
    .bus    (bus)
  );

  // Narrow counter so wrap-around is reachable in a short run.
  btn_io #(
    .NBTN      (5),
    .DEB_CYCLES(4),
    .CNT_W     (8)
  ) u_dut_w (
    .btn_clk(clk),
    .btn_rst(rst),
    .button (button),
    .bus    (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    bus.btn_addr  = {28'd0, off, 2'b00};
    bus.btn_we    = 1'b1;
    bus.btn_wdata = d;
    @(posedge clk);
    #1;
    bus.btn_we    = 1'b0;
    bus.btn_wdata = '0;
  endtask

  task automatic wr_w(input logic [1:0] off, input logic [31:0] d);
    bus_w.btn_addr  = {28'd0, off, 2'b00};
    bus_w.btn_we    = 1'b1;
    bus_w.btn_wdata = d;
    @(posedge clk);
    #1;
    bus_w.btn_we    = 1'b0;
    bus_w.btn_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    bus.btn_addr = {28'd0, off, 2'b00};
    #1;
    d = bus.rdata_btn2bridge;
  endtask

  task automatic rd_w(input logic [1:0] off, output logic [31:0] d);
    bus_w.btn_addr = {28'd0, off, 2'b00};
    #1;
    d = bus_w.rdata_btn2bridge;
  endtask

  task automatic clear_all();
    wr(BTN_OFF_PRESS, 32'h1F);
    wr(BTN_OFF_REL, 32'h1F);
    wr(BTN_OFF_COUNT, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_off%0d got=0x%08h exp=0x%08h", i, d, 32'h0);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    button = 5'b00001;
    tick(5);
    rd(BTN_OFF_LEVEL, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL latency_level_early got=0x%08h exp=0x%08h", d, 32'h0);
    end
    tick(1);
    rd(BTN_OFF_LEVEL, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL latency_level got=0x%08h exp=0x%08h", d, 32'h1);
    end
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL latency_press got=0x%08h exp=0x%08h", d, 32'h1);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL latency_count got=0x%08h exp=0x%08h", d, 32'h1);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    tick(1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL async_reset_off%0d got=0x%08h exp=0x%08h", i, d, 32'h0);
      end
    end
    tick(2);
    rst = 1'b0;
    // Button 0 still held: must come back as a fresh press.
    tick(5);
    rd(BTN_OFF_LEVEL, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL held_level_early got=0x%08h exp=0x%08h", d, 32'h0);
    end
    tick(1);
    rd(BTN_OFF_LEVEL, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL held_level got=0x%08h exp=0x%08h", d, 32'h1);
    end
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL held_press got=0x%08h exp=0x%08h", d, 32'h1);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL held_count got=0x%08h exp=0x%08h", d, 32'h1);
    end
    button = 5'b00000;
    tick(8);
    clear_all();
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    button = 5'b00100;
    tick(3);
    button = 5'b00000;
    tick(10);
    rd(BTN_OFF_LEVEL, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_level got=0x%08h exp=0x%08h", d, 32'h0);
    end
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_press got=0x%08h exp=0x%08h", d, 32'h0);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_count got=0x%08h exp=0x%08h", d, 32'h0);
    end
    button = 5'b00100;
    tick(4);
    button = 5'b00000;
    tick(12);
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL pulse4_press got=0x%08h exp=0x%08h", d, 32'h4);
    end
    rd(BTN_OFF_REL, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL pulse4_rel got=0x%08h exp=0x%08h", d, 32'h4);
    end
    rd(BTN_OFF_LEVEL, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL pulse4_level got=0x%08h exp=0x%08h", d, 32'h0);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL pulse4_count got=0x%08h exp=0x%08h", d, 32'h1);
    end
    clear_all();
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    button = 5'b00011;
    tick(6);
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL w1c_press_set got=0x%08h exp=0x%08h", d, 32'h3);
    end
    wr(BTN_OFF_PRESS, 32'h1);
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL w1c_clear_bit0 got=0x%08h exp=0x%08h", d, 32'h2);
    end
    button = 5'b00001;
    tick(8);
    rd(BTN_OFF_REL, d);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL w1c_rel_bit1 got=0x%08h exp=0x%08h", d, 32'h2);
    end
    button = 5'b00011;
    tick(5);
    wr(BTN_OFF_PRESS, 32'h2);  // lands on the edge where button 1 re-rises
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL w1c_set_wins got=0x%08h exp=0x%08h", d, 32'h2);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL w1c_count got=0x%08h exp=0x%08h", d, 32'h3);
    end
    button = 5'b00000;
    tick(8);
    clear_all();
  endtask

  task automatic test_count();
    logic [31:0] d;
    button = 5'b10001;
    tick(6);
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL count_two got=0x%08h exp=0x%08h", d, 32'h2);
    end
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h11) begin
      failures++;
      $display("FAIL count_press got=0x%08h exp=0x%08h", d, 32'h11);
    end
    button = 5'b00000;
    tick(8);
    button = 5'b10001;
    tick(5);
    wr(BTN_OFF_COUNT, 32'hDEAD);  // lands on the rise edge
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL count_write_rise got=0x%08h exp=0x%08h", d, 32'h2);
    end
    button = 5'b00000;
    tick(8);
    clear_all();
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    wr_w(BTN_OFF_COUNT, 32'h0);
    for (int r = 0; r < 51; r++) begin
      button = 5'b11111;
      tick(6);
      button = 5'b00000;
      tick(6);
    end
    tick(8);
    rd_w(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'hFF) begin
      failures++;
      $display("FAIL wrap_preload got=0x%08h exp=0x%08h", d, 32'hFF);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'hFF) begin
      failures++;
      $display("FAIL wide_preload got=0x%08h exp=0x%08h", d, 32'hFF);
    end
    button = 5'b00001;
    tick(6);
    rd_w(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL wrap_zero got=0x%08h exp=0x%08h", d, 32'h0);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h100) begin
      failures++;
      $display("FAIL wide_carry got=0x%08h exp=0x%08h", d, 32'h100);
    end
    button = 5'b00000;
    tick(8);
    clear_all();
  endtask

  task automatic test_ignored_writes();
    logic [31:0] d;
    button = 5'b00001;
    tick(6);
    wr(BTN_OFF_LEVEL, 32'hFFFF);
    rd(BTN_OFF_LEVEL, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL level_write_ignored got=0x%08h exp=0x%08h", d, 32'h1);
    end
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL level_write_press got=0x%08h exp=0x%08h", d, 32'h1);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL level_write_count got=0x%08h exp=0x%08h", d, 32'h1);
    end
    wr(BTN_OFF_PRESS, 32'h0);
    rd(BTN_OFF_PRESS, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL idle_w1c_press got=0x%08h exp=0x%08h", d, 32'h1);
    end
    rd(BTN_OFF_COUNT, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL idle_w1c_count got=0x%08h exp=0x%08h", d, 32'h1);
    end
    button = 5'b00000;
    tick(8);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    button          = 5'b00000;
    bus.btn_addr    = '0;
    bus.btn_we      = 1'b0;
    bus.btn_wdata   = '0;
    bus_w.btn_addr  = '0;
    bus_w.btn_we    = 1'b0;
    bus_w.btn_wdata = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    test_reset();
    test_latency();
    test_async_reset();
    test_glitch();
    test_w1c();
    test_count();
    test_wrap();
    test_ignored_writes();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
